sync_fifo_v2: RTL

Parametrised single-clock FIFO that succeeds the existing synchronous FIFO for the transfer-test datapath between the host-interface side and the local processing logic. Adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- run-time almost-empty/almost-full thresholds
- a live fill-level count
- sticky overflow/underflow error flags

Storage is a separate dual-port RAM sub-module.

---
 rtl/sync_fifo_v2_pkg.sv | 25 ++
 rtl/sync_fifo_v2_ram.sv | 34 +++
 rtl/sync_fifo_v2.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_v2_pkg.sv
//------------------------------------------------------------------------------
// sync_fifo_v2_pkg : shared constants and helpers for sync_fifo_v2
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sync_fifo_v2_pkg;

  localparam int FWFT_OFF     = 0;
  localparam int FWFT_ON      = 1;
  localparam int PARITY_MAX_W = 256;

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Zero-extended operands do not change the result.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_v2_ram.sv
//------------------------------------------------------------------------------
// sync_fifo_v2_ram : simple dual-port RAM, registered read port, no array reset
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_v2_ram
  import sync_fifo_v2_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_v2.sv
//------------------------------------------------------------------------------
// sync_fifo_v2 : single-clock FIFO, standard/FWFT read, thresholds, error flags
// Optional RAM parity enabled by macro SYNC_FIFO_V2_PARITY_EN
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_v2
  import sync_fifo_v2_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int FWFT       = FWFT_OFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wdata_valid,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_ack,
  input  logic                  read_req,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  rdata_valid,
  input  logic [ADDR_WIDTH:0]   aempty_thresh,
  input  logic [ADDR_WIDTH:0]   afull_thresh,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic                  fifo_empty,
  output logic                  fifo_aempty,
  output logic                  fifo_full,
  output logic                  fifo_afull,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  parity_err
);

  localparam int PTR_W = ADDR_WIDTH + 1;
`ifdef SYNC_FIFO_V2_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif
  localparam logic [PTR_W-1:0] LEVEL_MAX = PTR_W'(DEPTH);

  generate
    if (DEPTH != 2**ADDR_WIDTH || ptr_width(DEPTH) != PTR_W) begin : g_bad_depth
      $error("sync_fifo_v2: DEPTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic write_ack_q, write_ack_d, rvalid_q, rvalid_d;
  logic empty_q, empty_d, aempty_q, aempty_d, full_q, full_d, afull_q, afull_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  logic             block, wr_accept, ptr_empty;
  logic             pop, ram_re, rd_underflow, rvalid_next;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;

  assign block     = reset | flush;
  assign wr_accept = wdata_valid & ~full_q & ~block;
  assign ptr_empty = (wptr_q == rptr_q);

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // The RAM read register is the head register; refill whenever it frees up.
      assign pop          = read_req & rvalid_q & ~block;
      assign ram_re       = ~block & ~ptr_empty & (~rvalid_q | pop);
      assign rd_underflow = read_req & ~rvalid_q & ~block;
      assign rvalid_next  = ram_re | (rvalid_q & ~pop);
    end else begin : g_std
      assign pop          = read_req & ~ptr_empty & ~block;
      assign ram_re       = pop;
      assign rd_underflow = read_req & ptr_empty & ~block;
      assign rvalid_next  = pop;
    end
  endgenerate

  always_comb begin
    wptr_d      = wptr_q + PTR_W'(wr_accept);
    rptr_d      = rptr_q + PTR_W'(ram_re);
    level_d     = level_q + PTR_W'(wr_accept) - PTR_W'(pop);
    write_ack_d = wr_accept;
    rvalid_d    = rvalid_next;
    overflow_d  = overflow_q | (wdata_valid & full_q & ~block);
    underflow_d = underflow_q | rd_underflow;
    empty_d     = (level_d == '0);
    full_d      = (level_d == LEVEL_MAX);
    aempty_d    = (level_d <= aempty_thresh);
    afull_d     = (level_d >= afull_thresh);
    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      level_d     = '0;
      write_ack_d = 1'b0;
      rvalid_d    = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      empty_d     = 1'b1;
      full_d      = 1'b0;
      aempty_d    = 1'b1;
      afull_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      write_ack_q <= 1'b0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      aempty_q    <= 1'b1;
      afull_q     <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      write_ack_q <= write_ack_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      aempty_q    <= aempty_d;
      afull_q     <= afull_d;
    end
  end

`ifdef SYNC_FIFO_V2_PARITY_EN
  assign ram_wdata  = {even_parity(PARITY_MAX_W'(write_data)), write_data};
  assign parity_err = rvalid_q & (^ram_rdata);
`else
  assign ram_wdata  = write_data;
  assign parity_err = 1'b0;
`endif

  sync_fifo_v2_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (RAM_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
    .wr_data (ram_wdata),
    .rd_en   (ram_re),
    .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
    .rd_data (ram_rdata)
  );

  // RAM output is unreset, so mask it while no word is presented.
  assign read_data   = rvalid_q ? ram_rdata[DATA_WIDTH-1:0] : '0;
  assign rdata_valid = rvalid_q;
  assign write_ack   = write_ack_q;
  assign fifo_level  = level_q;
  assign fifo_empty  = empty_q;
  assign fifo_aempty = aempty_q;
  assign fifo_full   = full_q;
  assign fifo_afull  = afull_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

`default_nettype wire
